boot_ctrl: RTL
==============

# boot_ctrl

Program-load and run sequencer for the RISC core. Accepts a stream of 16-bit instructions over a valid/ready handshake, writes them into instruction memory from address 0, and holds the core in reset during the load. It then releases the core, gates execution with `core_en`, and stops the run when the core PC reaches the end of the loaded program. It sits between the host/test port and the core top, and replaces direct `inst_wen`/`input_inst` driving.

## Interface
- `ISA_WIDTH`, 16, instruction width
- `IMEM_ADDR_WIDTH`, 5, instruction memory address width (depth `DEPTH = 2**IMEM_ADDR_WIDTH` = 32)
- `RELEASE_CYC`, 2, cycles `core_rst_n` is held low after load/re-run; legal range 1..15
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `load_start` in 1: begin a new program load
- `s_valid` in 1: instruction beat valid
- `s_ready` out 1: controller accepts a beat
- `s_inst` in ISA_WIDTH: instruction word
- `s_last` in 1: current beat is the final instruction
- `imem_wen` out 1: instruction memory write enable
- `imem_addr` out IMEM_ADDR_WIDTH: write address
- `imem_wdata` out ISA_WIDTH: write data
- `core_rst_n` out 1: core reset, active-low
- `core_en` out 1: core execute enable
- `core_pc` in IMEM_ADDR_WIDTH+1: core program counter
- `run_req` in 1: start or re-run the program
- `halt_req` in 1: stop the run
- `prog_len` out IMEM_ADDR_WIDTH+1: number of instructions loaded
- `busy` out 1: state is LOAD, RELEASE or RUN
- `done` out 1: run completed
- `err` out 1: load overflow

## Operation
- States:
  - IDLE: core in reset, waiting for `load_start`.
  - LOAD: `s_ready`=1, accepting instruction beats.
  - RELEASE: holding `core_rst_n`=0 for `RELEASE_CYC` cycles.
  - HOLD: core out of reset, `core_en`=0, waiting for `run_req`.
  - RUN: `core_en`=1, core executing.
  - DONE: `done`=1, run finished.
  - ERR: `err`=1, load overflowed; core held in reset.
- IDLE/HOLD/DONE/ERR + `load_start`:
  - Go to LOAD.
  - Clear the write index, `prog_len`, `done` and `err`.
  - Drive `core_rst_n`=0 and `core_en`=0.
- `load_start` is ignored in LOAD, RELEASE and RUN.
- LOAD: a beat is accepted when `s_valid`&&`s_ready`.
  - The write index increments on each accepted beat.
  - Accepted beat with `s_last`: `prog_len`=index+1, go to RELEASE.
  - The DEPTH-th beat accepted without `s_last`: `prog_len`=DEPTH, go to ERR.
  - `s_valid` low: hold state; no timeout.
- RELEASE: count down `RELEASE_CYC` cycles with `core_rst_n`=0, then go to HOLD with `core_rst_n`=1.
- HOLD + `run_req`: go to RUN.
- RUN: on `halt_req`, or `core_pc` >= `prog_len`, go to DONE.
  - Both conditions in the same cycle produce a single transition to DONE.
- DONE:
  - `run_req` re-runs the program: go to RELEASE. The core reset pulse clears the PC.
  - `load_start` and `run_req` in the same cycle: `load_start` wins.
- ERR: `core_rst_n` is held at 0. The only exit is `load_start`.

## Timing
- Reset values of all outputs:
  - State IDLE.
  - `s_ready`, `imem_wen`, `core_en`, `done`, `err`, `busy` = 0.
  - `core_rst_n` = 0.
  - `imem_addr`, `imem_wdata`, `prog_len` = 0.
- `s_ready` is decoded from the registered state, so it is 1 from the first cycle in LOAD. It drops the cycle after the last or overflowing beat.
- Write latency is 1 cycle. A beat accepted at edge N produces `imem_wen`=1 with its address and data during cycle N+1. Back-to-back beats give continuous writes at addresses 0,1,2,…
- After the beat carrying `s_last`, `core_rst_n` rises exactly `RELEASE_CYC` cycles after the last `imem_wen` cycle.
- `core_en` rises the cycle after `run_req` is sampled in HOLD. It falls the cycle after the halt or PC-end condition is sampled. `done` rises in that same cycle.
- All outputs are registered except `s_ready` and `busy`, which are decoded from the state register.
- Asserting `rst` mid-load or mid-run forces the reset values immediately. Memory contents written so far are left as-is.

## Structure
- Shared package `boot_pkg`:
  - State enum: IDLE, LOAD, RELEASE, HOLD, RUN, DONE, ERR.
  - Default `RELEASE_CYC` value.
  - Opcode constants LOAD=000, STORE=001, MOVE=010, MAC=011, shared with the core decoder.
- No sub-module. The FSM, write index and release counter are inline.

## Test plan
- Load the 14-instruction MAC program (move r1 $1 … store r0 r6) with `s_last` on beat 14:
  - `imem_addr` 0..13 is written in order and `prog_len`=14.
  - `core_rst_n` rises 2 cycles after the last write.
  - After `run_req`, the run ends with `done`=1 and RAM[0]=697.
- Load a 1-beat program with `s_last` on the first beat: `prog_len`=1, one write at address 0.
- Stream 32 beats with no `s_last`: `err`=1 and `prog_len`=32. `core_rst_n` stays 0 and `s_ready`=0 until `load_start`.
- Assert `halt_req` in RUN on the same cycle that `core_pc`==`prog_len`: a single DONE transition, and `core_en`=0 on the next cycle.
- In DONE, assert `run_req` and `load_start` together: the controller enters LOAD. Assert `run_req` alone: RELEASE for 2 cycles, then HOLD.
- Assert `rst` low mid-LOAD after 5 beats: all outputs return to reset values immediately. After `rst` is released, a new load restarts at address 0.

Source files
------------

// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared state, timing and opcode definitions for the boot sequencer
//
// Purpose : types and constants shared by boot_ctrl and the core decoder.
// Contents: boot_state_t (sequencer states), RELEASE_CYC_DEF (default core
//           reset hold after a load or re-run), OP_* (3-bit core opcodes).
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RUN     = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } boot_state_t;

  localparam int RELEASE_CYC_DEF = 2;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_MOVE  = 3'b010;
  localparam logic [2:0] OP_MAC   = 3'b011;

endpackage

// File: rtl/boot_ctrl.sv
// rtl/boot_ctrl.sv - program-load and run sequencer for the RISC core
//
// Purpose : streams instructions into instruction memory from address 0 while
//           holding the core in reset, releases the core, gates execution and
//           stops the run when the PC passes the end of the loaded program.
// Ports   : clk, rst (async active-low)
//           load_start, run_req, halt_req     - host control
//           s_valid/s_ready/s_inst/s_last     - instruction stream
//           imem_wen/imem_addr/imem_wdata     - instruction memory write port
//           core_rst_n, core_en, core_pc      - core control / status
//           prog_len, busy, done, err         - status
module boot_ctrl
  import boot_pkg::*;
#(
  parameter int ISA_WIDTH       = 16,
  parameter int IMEM_ADDR_WIDTH = 5,
  parameter int RELEASE_CYC     = RELEASE_CYC_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_start,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [ISA_WIDTH-1:0]       s_inst,
  input  logic                       s_last,
  output logic                       imem_wen,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [ISA_WIDTH-1:0]       imem_wdata,
  output logic                       core_rst_n,
  output logic                       core_en,
  input  logic [IMEM_ADDR_WIDTH:0]   core_pc,
  input  logic                       run_req,
  input  logic                       halt_req,
  output logic [IMEM_ADDR_WIDTH:0]   prog_len,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int DEPTH = 2 ** IMEM_ADDR_WIDTH;
  localparam int LW    = IMEM_ADDR_WIDTH + 1;
  localparam logic [IMEM_ADDR_WIDTH-1:0] IDX_MAX = IMEM_ADDR_WIDTH'(DEPTH - 1);
  // Counter is loaded with RELEASE_CYC-1 so RELEASE lasts exactly RELEASE_CYC cycles.
  localparam logic [3:0] REL_INIT = 4'(RELEASE_CYC - 1);

  boot_state_t                state_q, state_d;
  logic [IMEM_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [3:0]                 rel_q, rel_d;
  logic [LW-1:0]              len_d;
  logic                       wen_d, rstn_d, en_d, done_d, err_d;
  logic [IMEM_ADDR_WIDTH-1:0] addr_d;
  logic [ISA_WIDTH-1:0]       wdata_d;
  logic                       can_load;

  assign s_ready  = (state_q == ST_LOAD);
  assign busy     = (state_q == ST_LOAD) || (state_q == ST_RELEASE) || (state_q == ST_RUN);
  assign can_load = (state_q == ST_IDLE) || (state_q == ST_HOLD) ||
                    (state_q == ST_DONE) || (state_q == ST_ERR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      rel_q      <= '0;
      prog_len   <= '0;
      imem_wen   <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
      core_en    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rel_q      <= rel_d;
      prog_len   <= len_d;
      imem_wen   <= wen_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      core_rst_n <= rstn_d;
      core_en    <= en_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rel_d   = rel_q;
    len_d   = prog_len;
    wen_d   = 1'b0;
    addr_d  = imem_addr;
    wdata_d = imem_wdata;
    rstn_d  = core_rst_n;
    en_d    = core_en;
    done_d  = done;
    err_d   = err;

    // load_start takes priority over run_req in every state that honours it.
    if (load_start && can_load) begin
      state_d = ST_LOAD;
      idx_d   = '0;
      len_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      rstn_d  = 1'b0;
      en_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (s_valid) begin
            wen_d   = 1'b1;
            addr_d  = idx_q;
            wdata_d = s_inst;
            idx_d   = idx_q + 1'b1;
            if (s_last) begin
              len_d   = {1'b0, idx_q} + LW'(1);
              rel_d   = REL_INIT;
              state_d = ST_RELEASE;
            end else if (idx_q == IDX_MAX) begin
              len_d   = LW'(DEPTH);
              err_d   = 1'b1;
              state_d = ST_ERR;
            end
          end
        end
        ST_RELEASE: begin
          if (rel_q == '0) begin
            rstn_d  = 1'b1;
            state_d = ST_HOLD;
          end else begin
            rel_d = rel_q - 1'b1;
          end
        end
        ST_HOLD: begin
          if (run_req) begin
            en_d    = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (halt_req || (core_pc >= prog_len)) begin
            en_d    = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          // Re-run pulses core reset again so the core restarts from PC 0.
          if (run_req) begin
            rstn_d  = 1'b0;
            done_d  = 1'b0;
            rel_d   = REL_INIT;
            state_d = ST_RELEASE;
          end
        end
        ST_IDLE, ST_ERR: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule
